// File: rtl/mem_arbiter.sv
// Three-way arbiter for a single-port synchronous RAM shared by j4 fetch (F),
// j4 data/IO (D) and an external loader (L); fixed D > F > L with starvation promotion.
module mem_arbiter #(
  parameter int WIDTH      = 16,
  parameter int PC_W       = 13,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f_req,
  input  logic [PC_W-1:0]  f_addr,
  output logic             f_gnt,
  output logic             f_rvalid,
  output logic [WIDTH-1:0] f_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [WIDTH-1:0] d_rdata,
  input  logic             l_req,
  input  logic             l_we,
  input  logic [WIDTH-1:0] l_addr,
  input  logic [WIDTH-1:0] l_wdata,
  output logic             l_gnt,
  output logic             l_rvalid,
  output logic [WIDTH-1:0] l_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [3:0] WAIT_SAT   = 4'd15;

  logic [3:0] wait_d_r, wait_f_r, wait_l_r;
  logic       d_rvalid_r, f_rvalid_r, l_rvalid_r;
  logic       urg_d_s, urg_f_s, urg_l_s;
  logic       d_gnt_s, f_gnt_s, l_gnt_s;
  logic       mem_we_s;
  logic [WIDTH-1:0] mem_addr_s, mem_wdata_s;

  // A waiting requester clears when it is served or gives up, and saturates otherwise.
  function automatic logic [3:0] next_wait(input logic req, input logic gnt, input logic [3:0] cur);
    logic [3:0] nxt;
    if (!req || gnt) begin
      nxt = 4'd0;
    end else if (cur == WAIT_SAT) begin
      nxt = WAIT_SAT;
    end else begin
      nxt = cur + 4'd1;
    end
    return nxt;
  endfunction

  // Winner selection: urgent class first, then D > F > L inside the class.
  always_comb begin
    urg_d_s = d_req && (wait_d_r >= STARVE_LIM);
    urg_f_s = f_req && (wait_f_r >= STARVE_LIM);
    urg_l_s = l_req && (wait_l_r >= STARVE_LIM);
    d_gnt_s = 1'b0;
    f_gnt_s = 1'b0;
    l_gnt_s = 1'b0;
    if (!rst_n) begin
      d_gnt_s = 1'b0;
    end else if (urg_d_s || urg_f_s || urg_l_s) begin
      d_gnt_s = urg_d_s;
      f_gnt_s = urg_f_s && !urg_d_s;
      l_gnt_s = urg_l_s && !urg_d_s && !urg_f_s;
    end else begin
      d_gnt_s = d_req;
      f_gnt_s = f_req && !d_req;
      l_gnt_s = l_req && !d_req && !f_req;
    end
  end

  // RAM command mux from the granted port; idle bus is all zero.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_addr_s  = '0;
    mem_wdata_s = '0;
    case ({d_gnt_s, f_gnt_s, l_gnt_s})
      3'b100: begin
        mem_we_s    = d_we;
        mem_addr_s  = d_addr;
        mem_wdata_s = d_wdata;
      end
      3'b010: begin
        mem_we_s    = 1'b0;
        mem_addr_s  = {{(WIDTH-PC_W){1'b0}}, f_addr};
        mem_wdata_s = '0;
      end
      3'b001: begin
        mem_we_s    = l_we;
        mem_addr_s  = l_addr;
        mem_wdata_s = l_wdata;
      end
      default: begin
        mem_we_s    = 1'b0;
        mem_addr_s  = '0;
        mem_wdata_s = '0;
      end
    endcase
  end

  // Starvation counters and one-cycle read-valid pipeline; reset drops in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_d_r   <= 4'd0;
      wait_f_r   <= 4'd0;
      wait_l_r   <= 4'd0;
      d_rvalid_r <= 1'b0;
      f_rvalid_r <= 1'b0;
      l_rvalid_r <= 1'b0;
    end else begin
      wait_d_r   <= next_wait(d_req, d_gnt_s, wait_d_r);
      wait_f_r   <= next_wait(f_req, f_gnt_s, wait_f_r);
      wait_l_r   <= next_wait(l_req, l_gnt_s, wait_l_r);
      d_rvalid_r <= d_gnt_s && !d_we;
      f_rvalid_r <= f_gnt_s;
      l_rvalid_r <= l_gnt_s && !l_we;
    end
  end

  assign d_gnt     = d_gnt_s;
  assign f_gnt     = f_gnt_s;
  assign l_gnt     = l_gnt_s;
  assign mem_en    = d_gnt_s | f_gnt_s | l_gnt_s;
  assign mem_we    = mem_we_s;
  assign mem_addr  = mem_addr_s;
  assign mem_wdata = mem_wdata_s;
  assign d_rvalid  = d_rvalid_r;
  assign f_rvalid  = f_rvalid_r;
  assign l_rvalid  = l_rvalid_r;
  assign d_rdata   = mem_rdata;
  assign f_rdata   = mem_rdata;
  assign l_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed test-plan steps followed by random traffic,
// all checked against a score-based arbitration model with a shadow memory.
module tb_mem_arbiter;
  localparam int WIDTH      = 16;
  localparam int PC_W       = 13;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic f_req, f_gnt, f_rvalid;
  logic [PC_W-1:0]  f_addr;
  logic [WIDTH-1:0] f_rdata;
  logic d_req, d_we, d_gnt, d_rvalid;
  logic [WIDTH-1:0] d_addr, d_wdata, d_rdata;
  logic l_req, l_we, l_gnt, l_rvalid;
  logic [WIDTH-1:0] l_addr, l_wdata, l_rdata;
  logic mem_en, mem_we;
  logic [WIDTH-1:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(WIDTH), .PC_W(PC_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Environment RAM: synchronous single port, with a preload path for setup.
  logic [WIDTH-1:0] ram [0:65535];
  logic [WIDTH-1:0] ram_q;
  logic             pl_en;
  logic [WIDTH-1:0] pl_addr, pl_data;
  always_ff @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else ram_q <= ram[mem_addr];
    end
  end
  assign mem_rdata = ram_q;

  // Reference model state (port index 0=D, 1=F, 2=L)
  logic [WIDTH-1:0] mm [0:65535];
  int               wt [3];
  bit               exp_rv [3];
  logic [WIDTH-1:0] exp_rd [3];
  string            nm [3] = '{"d", "f", "l"};
  int               compares;
  int               fails;
  logic [2:0]       obs_g;
  logic [2:0]       obs_rv;
  logic [WIDTH-1:0] obs_rd [3];
  logic [WIDTH-1:0] obs_ad;
  logic             obs_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs mid-cycle against the model, advance the model,
  // optionally pull reset low before the next rising edge.
  task automatic cycle(input bit rst_mid);
    bit               rq [3];
    bit               wr [3];
    logic [WIDTH-1:0] ad [3];
    logic [WIDTH-1:0] wd [3];
    int               best, bs, s;
    logic [2:0]       eg;
    @(negedge clk);
    rq = '{d_req, f_req, l_req};
    wr = '{d_we, 1'b0, l_we};
    ad = '{d_addr, {3'b000, f_addr}, l_addr};
    wd = '{d_wdata, 16'h0000, l_wdata};
    best = -1;
    bs = 0;
    for (int p = 0; p < 3; p++) begin
      if (rq[p] && rst_n) begin
        s = ((wt[p] >= STARVE_MAX) ? 10 : 0) + (3 - p);
        if (s > bs) begin
          bs = s;
          best = p;
        end
      end
    end
    eg = 3'b000;
    if (best >= 0) eg[2-best] = 1'b1;
    obs_g  = {d_gnt, f_gnt, l_gnt};
    obs_rv = {d_rvalid, f_rvalid, l_rvalid};
    obs_rd = '{d_rdata, f_rdata, l_rdata};
    obs_ad = mem_addr;
    obs_we = mem_we;
    chk("gnt", 32'(obs_g), 32'(eg));
    chk("mem_en", 32'(mem_en), 32'(best >= 0));
    chk("mem_addr", 32'(mem_addr), (best < 0) ? 32'd0 : 32'(ad[best]));
    chk("mem_we", 32'(mem_we), (best < 0) ? 32'd0 : 32'(wr[best]));
    chk("mem_wdata", 32'(mem_wdata), (best < 0) ? 32'd0 : 32'(wd[best]));
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("rvalid_%s", nm[p]), 32'(obs_rv[2-p]), 32'(exp_rv[p]));
      if (exp_rv[p]) chk($sformatf("rdata_%s", nm[p]), 32'(obs_rd[p]), 32'(exp_rd[p]));
    end
    for (int p = 0; p < 3; p++) begin
      exp_rv[p] = (best == p) && !wr[p];
      if (best == p && !wr[p]) exp_rd[p] = mm[ad[p]];
      if (best == p && wr[p]) mm[ad[p]] = wd[p];
      if (!rq[p] || best == p || !rst_n) wt[p] = 0;
      else wt[p] = (wt[p] >= 15) ? 15 : wt[p] + 1;
    end
    if (rst_mid) begin
      rst_n = 1'b0;
      for (int p = 0; p < 3; p++) begin
        exp_rv[p] = 1'b0;
        wt[p] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    compares = 0;
    fails = 0;
    for (int p = 0; p < 3; p++) begin
      wt[p] = 0;
      exp_rv[p] = 1'b0;
      exp_rd[p] = 16'h0000;
    end
    rst_n = 1'b0;
    pl_en = 1'b0; pl_addr = 16'h0000; pl_data = 16'h0000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
    f_req = 1'b1; f_addr = 13'h0000;
    l_req = 1'b1; l_we = 1'b0; l_addr = 16'h0000; l_wdata = 16'h0000;

    // Preload RAM and shadow memory while held in reset
    pl_en = 1'b1;
    for (int i = 0; i < 34; i++) begin
      pl_addr = (i == 32) ? 16'h0005 : (i == 33) ? 16'h0100 : 16'(i);
      pl_data = (i == 32) ? 16'hABCD : (i == 33) ? 16'h0000 : 16'($urandom);
      mm[pl_addr] = pl_data;
      @(posedge clk);
      #1;
    end
    pl_en = 1'b0;

    // Reset with all requests high: no grants, no rvalid
    cycle(1'b0);
    cycle(1'b0);
    chk("rst_no_gnt", 32'(obs_g), 32'd0);
    rst_n = 1'b1;
    cycle(1'b0);
    chk("rel_d_first", 32'(obs_g), 32'b100);
    d_req = 1'b0; f_req = 1'b0; l_req = 1'b0;
    cycle(1'b0);

    // Fetch only
    f_req = 1'b1; f_addr = 13'h0005;
    cycle(1'b0);
    chk("fetch_gnt", 32'(obs_g), 32'b010);
    chk("fetch_addr", 32'(obs_ad), 32'h0005);
    f_req = 1'b0;
    cycle(1'b0);
    chk("fetch_rvalid", 32'(obs_rv), 32'b010);
    chk("fetch_rdata", 32'(obs_rd[1]), 32'hABCD);

    // Contention D vs F
    d_req = 1'b1; d_addr = 16'h0010; f_req = 1'b1; f_addr = 13'h0005;
    cycle(1'b0);
    chk("cont_c0", 32'(obs_g), 32'b100);
    d_req = 1'b0;
    cycle(1'b0);
    chk("cont_c1", 32'(obs_g), 32'b010);
    f_req = 1'b0;
    cycle(1'b0);
    chk("cont_c2_rv", 32'(obs_rv), 32'b010);

    // Starvation promotion of F
    d_req = 1'b1; f_req = 1'b1; f_addr = 13'h0007;
    for (int i = 0; i < 6; i++) begin
      d_addr = 16'h0010 + 16'(i);
      cycle(1'b0);
      chk($sformatf("starve_c%0d", i), 32'(obs_g), (i == 4) ? 32'b010 : 32'b100);
    end
    d_req = 1'b0; f_req = 1'b0;
    cycle(1'b0);

    // D write then L read of the same word
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0100; d_wdata = 16'h1234;
    cycle(1'b0);
    chk("wr_mem_we", 32'(obs_we), 32'd1);
    d_req = 1'b0; d_we = 1'b0;
    l_req = 1'b1; l_we = 1'b0; l_addr = 16'h0100;
    cycle(1'b0);
    chk("rd_l_gnt", 32'(obs_g), 32'b001);
    chk("wr_no_rvalid", 32'(obs_rv), 32'd0);
    l_req = 1'b0;
    cycle(1'b0);
    chk("rd_l_rvalid", 32'(obs_rv), 32'b001);
    chk("rd_l_rdata", 32'(obs_rd[2]), 32'h1234);

    // Reset asserted after an L read grant, before the next edge
    l_req = 1'b1; l_addr = 16'h0003;
    cycle(1'b1);
    chk("midrst_gnt", 32'(obs_g), 32'b001);
    l_req = 1'b0;
    cycle(1'b0);
    chk("midrst_drop", 32'(obs_rv), 32'd0);
    rst_n = 1'b1;
    cycle(1'b0);
    chk("midrst_rel0", 32'(obs_rv), 32'd0);
    cycle(1'b0);
    chk("midrst_rel1", 32'(obs_rv), 32'd0);

    // Random traffic; ports hold their request until granted
    for (int n = 0; n < 400; n++) begin
      if (!d_req || obs_g[2]) begin
        d_req = ($urandom_range(0, 9) < 6);
        d_we = 1'($urandom_range(0, 1));
        d_addr = 16'($urandom_range(0, 31));
        d_wdata = 16'($urandom);
      end else if ($urandom_range(0, 29) == 0) d_req = 1'b0;
      if (!f_req || obs_g[1]) begin
        f_req = ($urandom_range(0, 9) < 5);
        f_addr = 13'($urandom_range(0, 31));
      end else if ($urandom_range(0, 29) == 0) f_req = 1'b0;
      if (!l_req || obs_g[0]) begin
        l_req = ($urandom_range(0, 9) < 5);
        l_we = 1'($urandom_range(0, 1));
        l_addr = 16'($urandom_range(0, 31));
        l_wdata = 16'($urandom);
      end else if ($urandom_range(0, 29) == 0) l_req = 1'b0;
      cycle(1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end
endmodule
